// File: rtl/mtm_alu_frame_serializer.sv
// mtm_alu_frame_serializer: sends one ALU result word plus its CTL byte per
//   valid/ready handshake as UART-style packets on a single wire, one bit per clk.
// Latency: start bit appears on sout the cycle after the accepting edge; sout is registered.
// Backpressure: in_ready is high only in IDLE (and low during rst); a frame in flight blocks new input.
// Ports: clk/rst (sync, active-high); data_in/ctl_in/in_valid/in_ready input handshake;
//   sout serial line (idle high); busy while a frame is in flight; tx_done on the final stop cycle.
// Optional feature macro SER_PARITY_EN: adds an even-parity bit (over flag + payload) after bit0.
module mtm_alu_frame_serializer #(
  parameter int DATA_BYTES = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic [7:0]              ctl_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    sout,
  output logic                    busy,
  output logic                    tx_done
);

  localparam int BCW = $clog2(DATA_BYTES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(DATA_BYTES);
  localparam logic [1:0]     LAST_STOP = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FLAG,
    S_BITS,
`ifdef SER_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  state_t                  state_q;
  logic [2:0]              bit_cnt_q;
  logic [BCW-1:0]          byte_cnt_q;
  logic [1:0]              stop_cnt_q;
  logic [8*DATA_BYTES-1:0] data_q;
  logic [7:0]              ctl_q;
  logic                    sout_q;
  logic                    busy_q;
  logic                    tx_done_q;

  logic                    last_pkt;
  logic [7:0]              cur_byte;

  // The cmd packet is the one where byte_cnt has reached DATA_BYTES; it is also
  // the last packet of every frame, and its flag bit is 1.
  assign last_pkt = (byte_cnt_q == LAST_BYTE);

  always_comb begin
    cur_byte = ctl_q;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (byte_cnt_q == BCW'(i)) cur_byte = data_q[8*(DATA_BYTES-1-i) +: 8];
    end
  end

  assign in_ready = (state_q == S_IDLE) && !rst;
  assign sout     = sout_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

  // Every transition loads sout_q with the bit belonging to the state being entered,
  // so the line value and the state stay aligned cycle for cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      stop_cnt_q <= '0;
      data_q     <= '0;
      ctl_q      <= '0;
      sout_q     <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sout_q    <= 1'b1;
          busy_q    <= 1'b0;
          tx_done_q <= 1'b0;
          if (in_valid) begin
            data_q     <= data_in;
            ctl_q      <= ctl_in;
            // Error frames skip straight to the cmd packet.
            byte_cnt_q <= ctl_in[7] ? LAST_BYTE : '0;
            state_q    <= S_START;
            sout_q     <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_START: begin
          state_q <= S_FLAG;
          sout_q  <= last_pkt;
        end
        S_FLAG: begin
          state_q   <= S_BITS;
          bit_cnt_q <= 3'd7;
          sout_q    <= cur_byte[7];
        end
        S_BITS: begin
          if (bit_cnt_q == 3'd0) begin
`ifdef SER_PARITY_EN
            state_q <= S_PAR;
            sout_q  <= ^{last_pkt, cur_byte};
`else
            state_q    <= S_STOP;
            stop_cnt_q <= '0;
            sout_q     <= 1'b1;
            tx_done_q  <= last_pkt && (STOP_BITS == 1);
`endif
          end else begin
            bit_cnt_q <= bit_cnt_q - 3'd1;
            sout_q    <= cur_byte[bit_cnt_q - 3'd1];
          end
        end
`ifdef SER_PARITY_EN
        S_PAR: begin
          state_q    <= S_STOP;
          stop_cnt_q <= '0;
          sout_q     <= 1'b1;
          tx_done_q  <= last_pkt && (STOP_BITS == 1);
        end
`endif
        S_STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            tx_done_q <= 1'b0;
            if (last_pkt) begin
              state_q <= S_IDLE;
              sout_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              byte_cnt_q <= byte_cnt_q + BCW'(1);
              state_q    <= S_START;
              sout_q     <= 1'b0;
            end
          end else begin
            stop_cnt_q <= stop_cnt_q + 2'd1;
            sout_q     <= 1'b1;
            // Pulse lands on the last stop cycle of the last packet.
            tx_done_q  <= last_pkt && ((stop_cnt_q + 2'd1) == LAST_STOP);
          end
        end
        default: begin
          state_q <= S_IDLE;
          sout_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_frame_serializer.sv
// tb_mtm_alu_frame_serializer: directed bench for the frame serializer.
// Instance dut uses DATA_BYTES=4/STOP_BITS=1, instance dut2 uses DATA_BYTES=1/STOP_BITS=2.
// Expected bit streams are hand-written literals or built from the packet format.
module tb_mtm_alu_frame_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] data_in;
  logic [7:0]  ctl_in;
  logic        in_valid, in_ready, sout, busy, tx_done;

  logic [7:0]  data_in2;
  logic [7:0]  ctl_in2;
  logic        in_valid2, in_ready2, sout2, busy2, tx_done2;

  mtm_alu_frame_serializer #(.DATA_BYTES(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .ctl_in(ctl_in), .in_valid(in_valid),
    .in_ready(in_ready), .sout(sout), .busy(busy), .tx_done(tx_done)
  );

  mtm_alu_frame_serializer #(.DATA_BYTES(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .data_in(data_in2), .ctl_in(ctl_in2), .in_valid(in_valid2),
    .in_ready(in_ready2), .sout(sout2), .busy(busy2), .tx_done(tx_done2)
  );

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_lit(input logic [127:0] v, input int len);
    exp_q.delete();
    for (int i = len - 1; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  task automatic add_pkt(input bit flag, input logic [7:0] b, input int stops);
    exp_q.push_back(1'b0);
    exp_q.push_back(flag);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
`ifdef SER_PARITY_EN
    exp_q.push_back(^{flag, b});
`endif
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  task automatic build(input logic [63:0] d, input int nbytes, input logic [7:0] c, input int stops);
    exp_q.delete();
    if (!c[7]) begin
      for (int i = nbytes - 1; i >= 0; i--) add_pkt(1'b0, d[8*i +: 8], stops);
    end
    add_pkt(1'b1, c, stops);
  endtask

  // Present a frame; returns at the negedge of the first (start) bit.
  task automatic present(input logic [31:0] d, input logic [7:0] c);
    data_in  = d;
    ctl_in   = c;
    in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic present2(input logic [7:0] d, input logic [7:0] c);
    data_in2  = d;
    ctl_in2   = c;
    in_valid2 = 1'b1;
    @(negedge clk);
  endtask

  // Samples exp_q.size() bits starting at the current negedge, then checks the idle cycle.
  task automatic check_frame(input string tag, input bit sel);
    int           len;
    logic [127:0] ov, ev;
    logic         s, b, t, r;
    logic         busy_ok, rdy_low, td_last;
    int           td_cnt;
    len = exp_q.size();
    ov = '0; ev = '0; busy_ok = 1'b1; rdy_low = 1'b1; td_last = 1'b0; td_cnt = 0;
    for (int i = 0; i < len; i++) begin
      s = sel ? sout2 : sout;
      b = sel ? busy2 : busy;
      t = sel ? tx_done2 : tx_done;
      r = sel ? in_ready2 : in_ready;
      ov = {ov[126:0], s};
      ev = {ev[126:0], exp_q[i]};
      if (!b) busy_ok = 1'b0;
      if (r) rdy_low = 1'b0;
      if (t) begin
        td_cnt++;
        if (i == len - 1) td_last = 1'b1;
      end
      @(negedge clk);
    end
    chk({tag, ".bits"}, ov, ev);
    chk({tag, ".busy_high"}, 128'(busy_ok), 128'd1);
    chk({tag, ".ready_low"}, 128'(rdy_low), 128'd1);
    chk({tag, ".done_count"}, 128'(td_cnt), 128'd1);
    chk({tag, ".done_on_last"}, 128'(td_last), 128'd1);
    chk({tag, ".idle_sout"}, 128'(sel ? sout2 : sout), 128'd1);
    chk({tag, ".idle_busy"}, 128'(sel ? busy2 : busy), 128'd0);
    chk({tag, ".idle_ready"}, 128'(sel ? in_ready2 : in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] ov, ev;
    int           td_seen;
    rst = 1'b1; in_valid = 1'b0; data_in = '0; ctl_in = '0;
    in_valid2 = 1'b0; data_in2 = '0; ctl_in2 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset.sout", 128'(sout), 128'd1);
    chk("reset.busy", 128'(busy), 128'd0);
    chk("reset.tx_done", 128'(tx_done), 128'd0);
    chk("reset.in_ready", 128'(in_ready), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset.in_ready", 128'(in_ready), 128'd1);
    chk("post_reset.sout", 128'(sout), 128'd1);

    // T1: normal frame, hand-written stream.
`ifdef SER_PARITY_EN
    load_lit(60'b00_00010010_0_1_00_00110100_1_1_00_01010110_0_1_00_01111000_0_1_01_00000101_1_1, 60);
`else
    load_lit(55'b00_00010010_1_00_00110100_1_00_01010110_1_00_01111000_1_01_00000101_1, 55);
`endif
    present(32'h12345678, 8'h05);
    in_valid = 1'b0;
    check_frame("T1", 1'b0);

    // T2: error frame, cmd packet only.
`ifdef SER_PARITY_EN
    load_lit(12'b01_11001001_1_1, 12);
`else
    load_lit(11'b01_11001001_1, 11);
`endif
    present(32'hCAFEF00D, 8'hC9);
    in_valid = 1'b0;
    check_frame("T2", 1'b0);

    // T3: in_valid held across two frames; inputs move to frame 2 right after accept.
    build(64'hDEADBEEF, 4, 8'h02, 1);
    present(32'hDEADBEEF, 8'h02);
    data_in = 32'h00000001;
    ctl_in  = 8'h03;
    check_frame("T3a", 1'b0);
    build(64'h00000001, 4, 8'h03, 1);
    present(32'h00000001, 8'h03);
    in_valid = 1'b0;
    check_frame("T3b", 1'b0);

    // T4: reset during bit 20 of the T1 frame.
    build(64'h12345678, 4, 8'h05, 1);
    present(32'h12345678, 8'h05);
    in_valid = 1'b0;
    ov = '0; ev = '0;
    for (int i = 0; i < 20; i++) begin
      ov = {ov[126:0], sout};
      ev = {ev[126:0], exp_q[i]};
      if (i < 19) @(negedge clk);
    end
    chk("T4.partial_bits", ov, ev);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("T4.abort_sout", 128'(sout), 128'd1);
    chk("T4.abort_busy", 128'(busy), 128'd0);
    td_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx_done || !sout) td_seen++;
    end
    chk("T4.quiet_after_abort", 128'(td_seen), 128'd0);
    build(64'h12345678, 4, 8'h05, 1);
    present(32'h12345678, 8'h05);
    in_valid = 1'b0;
    check_frame("T4.resend", 1'b0);

    // T5: inputs change after capture; line must carry the captured word.
    build(64'hA5A50F0F, 4, 8'h11, 1);
    present(32'hA5A50F0F, 8'h11);
    in_valid = 1'b0;
    data_in  = 32'hFFFFFFFF;
    ctl_in   = 8'h80;
    check_frame("T5", 1'b0);

    // T6: one data byte, two stop bits.
`ifdef SER_PARITY_EN
    load_lit(26'b00_10000001_0_11_01_00010000_0_11, 26);
`else
    load_lit(24'b00_10000001_11_01_00010000_11, 24);
`endif
    present2(8'h81, 8'h10);
    in_valid2 = 1'b0;
    check_frame("T6", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
